// File: rtl/status_stat_hwm.sv
// Multi-channel flow statistics: live occupancy, high-water mark, saturating accept count and
// sticky error flags per channel, with coherent snapshot and an indexed 1-cycle read port.
module status_stat_hwm #(
    parameter int unsigned els_p        = 4,
    parameter int unsigned total_stat_p = 3,
    parameter int unsigned cnt_width_p  = 32,
    localparam int unsigned width_lp     = $clog2(els_p + 1),
    localparam int unsigned sel_width_lp = (total_stat_p == 1) ? 1 : $clog2(total_stat_p)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [total_stat_p-1:0]                  v_i,
    input  logic [total_stat_p-1:0]                  ready_i,
    input  logic [total_stat_p-1:0]                  yumi_i,
    input  logic [total_stat_p-1:0]                  clear_i,
    input  logic                                     snap_i,
    input  logic                                     rd_v_i,
    input  logic [sel_width_lp-1:0]                  rd_sel_i,
    output logic [total_stat_p-1:0][width_lp-1:0]    count_o,
    output logic                                     rd_v_o,
    output logic [width_lp-1:0]                      rd_count_o,
    output logic [width_lp-1:0]                      rd_hwm_o,
    output logic [cnt_width_p-1:0]                   rd_total_o,
    output logic [1:0]                               rd_err_o
);

    logic [total_stat_p-1:0][width_lp-1:0]    count_q, count_d, hwm_q, hwm_d;
    logic [total_stat_p-1:0][cnt_width_p-1:0] total_q, total_d;
    logic [total_stat_p-1:0]                  ovf_q, ovf_d, unf_q, unf_d;
    logic [total_stat_p-1:0]                  inc, dec, ovf_ev, unf_ev;

    logic [total_stat_p-1:0][width_lp-1:0]    sh_count_q, sh_hwm_q;
    logic [total_stat_p-1:0][cnt_width_p-1:0] sh_total_q;
    logic [total_stat_p-1:0]                  sh_ovf_q, sh_unf_q;

    logic                                     rd_v_q;
    logic [width_lp-1:0]                      rd_count_q, rd_hwm_q;
    logic [cnt_width_p-1:0]                   rd_total_q;
    logic [1:0]                               rd_err_q;
    logic                                     sel_ok;

    assign inc    = v_i & ready_i;
    assign dec    = yumi_i;
    assign sel_ok = 32'(rd_sel_i) < total_stat_p;

    always_comb begin
        count_d = count_q;
        hwm_d   = hwm_q;
        total_d = total_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        ovf_ev  = '0;
        unf_ev  = '0;
        for (int i = 0; i < total_stat_p; i++) begin
            if (inc[i] && !dec[i]) begin
                if (count_q[i] == width_lp'(els_p)) begin
                    ovf_ev[i] = 1'b1;
                end else begin
                    count_d[i] = count_q[i] + 1'b1;
                end
            end else if (dec[i] && !inc[i]) begin
                if (count_q[i] == '0) begin
                    unf_ev[i] = 1'b1;
                end else begin
                    count_d[i] = count_q[i] - 1'b1;
                end
            end

            // Clear rebases the watermark on the post-update occupancy; errors in the
            // clearing cycle still stick.
            if (clear_i[i]) begin
                hwm_d[i]   = count_d[i];
                total_d[i] = '0;
                ovf_d[i]   = ovf_ev[i];
                unf_d[i]   = unf_ev[i];
            end else begin
                if (count_d[i] > hwm_q[i]) begin
                    hwm_d[i] = count_d[i];
                end
                if (inc[i] && (total_q[i] != '1)) begin
                    total_d[i] = total_q[i] + 1'b1;
                end
                ovf_d[i] = ovf_q[i] | ovf_ev[i];
                unf_d[i] = unf_q[i] | unf_ev[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q    <= '0;
            hwm_q      <= '0;
            total_q    <= '0;
            ovf_q      <= '0;
            unf_q      <= '0;
            sh_count_q <= '0;
            sh_hwm_q   <= '0;
            sh_total_q <= '0;
            sh_ovf_q   <= '0;
            sh_unf_q   <= '0;
            rd_v_q     <= 1'b0;
            rd_count_q <= '0;
            rd_hwm_q   <= '0;
            rd_total_q <= '0;
            rd_err_q   <= '0;
        end else begin
            count_q <= count_d;
            hwm_q   <= hwm_d;
            total_q <= total_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;

            // Shadow takes pre-update values, so a same-cycle read sees the old snapshot.
            if (snap_i) begin
                sh_count_q <= count_q;
                sh_hwm_q   <= hwm_q;
                sh_total_q <= total_q;
                sh_ovf_q   <= ovf_q;
                sh_unf_q   <= unf_q;
            end

            rd_v_q <= rd_v_i;
            if (rd_v_i) begin
                if (sel_ok) begin
                    rd_count_q <= sh_count_q[rd_sel_i];
                    rd_hwm_q   <= sh_hwm_q[rd_sel_i];
                    rd_total_q <= sh_total_q[rd_sel_i];
                    rd_err_q   <= {sh_ovf_q[rd_sel_i], sh_unf_q[rd_sel_i]};
                end else begin
                    rd_count_q <= '0;
                    rd_hwm_q   <= '0;
                    rd_total_q <= '0;
                    rd_err_q   <= '0;
                end
            end
        end
    end

    assign count_o    = count_q;
    assign rd_v_o     = rd_v_q;
    assign rd_count_o = rd_count_q;
    assign rd_hwm_o   = rd_hwm_q;
    assign rd_total_o = rd_total_q;
    assign rd_err_o   = rd_err_q;

endmodule

// File: tb/tb_status_stat_hwm.sv
// Self-checking bench for status_stat_hwm: read responses are scoreboarded, occupancy and
// reset behaviour are checked directly.
module tb_status_stat_hwm;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [2:0]       v_i, ready_i, yumi_i, clear_i;
    logic             snap_i, rd_v_i;
    logic [1:0]       rd_sel_i;
    logic [2:0][2:0]  count_o;
    logic             rd_v_o;
    logic [2:0]       rd_count_o, rd_hwm_o;
    logic [7:0]       rd_total_o;
    logic [1:0]       rd_err_o;

    typedef struct {
        logic [2:0] cnt;
        logic [2:0] hwm;
        logic [7:0] tot;
        logic [1:0] err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    status_stat_hwm #(
        .els_p        (4),
        .total_stat_p (3),
        .cnt_width_p  (8)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .v_i        (v_i),
        .ready_i    (ready_i),
        .yumi_i     (yumi_i),
        .clear_i    (clear_i),
        .snap_i     (snap_i),
        .rd_v_i     (rd_v_i),
        .rd_sel_i   (rd_sel_i),
        .count_o    (count_o),
        .rd_v_o     (rd_v_o),
        .rd_count_o (rd_count_o),
        .rd_hwm_o   (rd_hwm_o),
        .rd_total_o (rd_total_o),
        .rd_err_o   (rd_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] y, input logic [2:0] c,
                         input logic s);
        v_i      = a;
        ready_i  = a;
        yumi_i   = y;
        clear_i  = c;
        snap_i   = s;
        rd_v_i   = 1'b0;
        rd_sel_i = 2'd0;
    endtask

    task automatic step(input logic [2:0] a, input logic [2:0] y, input logic [2:0] c,
                        input logic s);
        drive(a, y, c, s);
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] sel, input logic s, input logic [2:0] c,
                      input logic [2:0] h, input logic [7:0] t, input logic [1:0] e);
        exp_t x;
        drive(3'b000, 3'b000, 3'b000, s);
        rd_v_i   = 1'b1;
        rd_sel_i = sel;
        x.cnt = c;
        x.hwm = h;
        x.tot = t;
        x.err = e;
        sb.push_back(x);
        @(negedge clk);
    endtask

    // Read-response monitor, sampling 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_i) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rd_v", rd_v_o, 1);
                    check("rd_count", rd_count_o, e.cnt);
                    check("rd_hwm", rd_hwm_o, e.hwm);
                    check("rd_total", rd_total_o, e.tot);
                    check("rd_err", rd_err_o, e.err);
                end else begin
                    check("rd_v_idle", rd_v_o, 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1;
        drive(3'b000, 3'b000, 3'b000, 1'b0);
        #3;
        check("rst_count", count_o, 0);
        check("rst_rd_v", rd_v_o, 0);
        check("rst_rd_data", {rd_count_o, rd_hwm_o, rd_total_o, rd_err_o}, 0);
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;

        // Valid without ready is not an accept.
        drive(3'b000, 3'b000, 3'b000, 1'b0);
        v_i = 3'b010;
        @(negedge clk);
        check("no_ready", count_o[1], 0);

        // Fill/drain on ch1.
        repeat (3) step(3'b010, 3'b000, 3'b000, 1'b0);
        check("fill_ch1", count_o[1], 3);
        step(3'b000, 3'b010, 3'b000, 1'b0);
        check("drain_ch1", count_o[1], 2);
        step(3'b000, 3'b000, 3'b000, 1'b1);
        rd(2'd1, 1'b0, 3'd2, 3'd3, 8'd3, 2'b00);
        rd(2'd0, 1'b0, 3'd0, 3'd0, 8'd0, 2'b00);
        rd(2'd2, 1'b0, 3'd0, 3'd0, 8'd0, 2'b00);

        // Overflow then underflow on ch0.
        repeat (5) step(3'b001, 3'b000, 3'b000, 1'b0);
        check("ovf_hold", count_o[0], 4);
        repeat (5) step(3'b000, 3'b001, 3'b000, 1'b0);
        check("unf_hold", count_o[0], 0);
        step(3'b000, 3'b000, 3'b000, 1'b1);
        rd(2'd0, 1'b0, 3'd0, 3'd4, 8'd5, 2'b11);

        // Simultaneous inc/dec at empty and at full.
        step(3'b000, 3'b000, 3'b001, 1'b0);
        step(3'b001, 3'b001, 3'b000, 1'b0);
        check("cut_through_0", count_o[0], 0);
        repeat (4) step(3'b001, 3'b000, 3'b000, 1'b0);
        step(3'b001, 3'b001, 3'b000, 1'b0);
        check("both_at_full", count_o[0], 4);
        step(3'b000, 3'b000, 3'b000, 1'b1);
        rd(2'd0, 1'b0, 3'd4, 3'd4, 8'd6, 2'b00);

        // Saturation and clear on ch2.
        repeat (300) step(3'b100, 3'b100, 3'b000, 1'b0);
        repeat (3) step(3'b100, 3'b000, 3'b000, 1'b0);
        repeat (2) step(3'b000, 3'b100, 3'b000, 1'b0);
        step(3'b000, 3'b000, 3'b000, 1'b1);
        rd(2'd2, 1'b0, 3'd1, 3'd3, 8'd255, 2'b00);
        step(3'b100, 3'b000, 3'b100, 1'b0);
        step(3'b000, 3'b000, 3'b000, 1'b1);
        rd(2'd2, 1'b0, 3'd2, 3'd2, 8'd0, 2'b00);
        repeat (2) step(3'b000, 3'b100, 3'b000, 1'b0);
        step(3'b000, 3'b100, 3'b100, 1'b0);
        step(3'b000, 3'b000, 3'b000, 1'b1);
        rd(2'd2, 1'b0, 3'd0, 3'd0, 8'd0, 2'b01);

        // Snapshot coherency and read timing on ch0.
        repeat (4) step(3'b000, 3'b001, 3'b000, 1'b0);
        step(3'b000, 3'b000, 3'b001, 1'b0);
        repeat (2) step(3'b001, 3'b000, 3'b000, 1'b0);
        step(3'b001, 3'b000, 3'b000, 1'b1);
        check("snap_live", count_o[0], 3);
        rd(2'd0, 1'b0, 3'd2, 3'd2, 8'd2, 2'b00);
        rd(2'd0, 1'b1, 3'd2, 3'd2, 8'd2, 2'b00);
        rd(2'd3, 1'b0, 3'd0, 3'd0, 8'd0, 2'b00);
        rd(2'd0, 1'b0, 3'd3, 3'd3, 8'd3, 2'b00);
        step(3'b000, 3'b000, 3'b000, 1'b0);
        check("hold_count", rd_count_o, 3);
        check("hold_total", rd_total_o, 3);
        check("ch1_indep", count_o[1], 2);

        // Async reset between edges with a read pending and rd_v_o high.
        rd(2'd0, 1'b0, 3'd3, 3'd3, 8'd3, 2'b00);
        drive(3'b001, 3'b000, 3'b000, 1'b0);
        rd_v_i = 1'b1;
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_count", count_o, 0);
        check("arst_rd_v", rd_v_o, 0);
        check("arst_rd_data", {rd_count_o, rd_hwm_o, rd_total_o, rd_err_o}, 0);
        @(negedge clk);
        reset_i = 1'b0;
        rd(2'd0, 1'b0, 3'd0, 3'd0, 8'd0, 2'b00);
        rd(2'd1, 1'b0, 3'd0, 3'd0, 8'd0, 2'b00);
        check("post_rst_count", count_o, 0);

        repeat (2) step(3'b000, 3'b000, 3'b000, 1'b0);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/status_stat_hwm.md
Name: status_stat_hwm

Overview:
- Multi-channel flow statistics block, successor to the per-channel occupancy counter bank.
- Per channel it tracks:
  - live occupancy;
  - high-water mark;
  - a saturating total-accept count;
  - sticky overflow/underflow error flags.
- All channels are captured atomically into shadow registers on a snapshot strobe.
- Software reads the shadow registers one channel at a time through an indexed, 1-cycle-latency port; sits between datapath FIFOs and the status CSR block.

Parameters:
- els_p, (required), max occupancy per channel; count width = `BSG_WIDTH(els_p)
- total_stat_p, (required), number of channels
- cnt_width_p, 32, width of the saturating total-accept counter
- sel_width_lp, `BSG_SAFE_CLOG2(total_stat_p), local, read index width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- v_i  in  total_stat_p  per-channel producer valid
- ready_i  in  total_stat_p  per-channel consumer ready
- yumi_i  in  total_stat_p  per-channel dequeue
- clear_i  in  total_stat_p  per-channel clear of hwm/total/error state
- snap_i  in  1  capture all channels into shadow registers
- rd_v_i  in  1  read request
- rd_sel_i  in  sel_width_lp  channel index to read
- count_o  out  total_stat_p x `BSG_WIDTH(els_p)  live occupancy, registered
- rd_v_o  out  1  read data valid
- rd_count_o  out  `BSG_WIDTH(els_p)  shadow occupancy
- rd_hwm_o  out  `BSG_WIDTH(els_p)  shadow high-water mark
- rd_total_o  out  cnt_width_p  shadow total-accept count
- rd_err_o  out  2  shadow {ovf, unf} sticky flags

Behaviour:
- Reset (async assert, any cycle, including mid-read): all live and shadow state = 0; count_o = 0; rd_v_o = 0; all rd_*_o = 0.
- Per-channel events: inc = v_i & ready_i; dec = yumi_i.
- Occupancy update:
  - inc & !dec: count+1.
  - dec & !inc: count-1.
  - Both or neither: unchanged (cut-through at count 0 legal).
- Overflow: inc & !dec with count == els_p: count holds at els_p, ovf sticky set.
- Underflow: dec & !inc with count == 0: count holds at 0, unf sticky set.
- High-water mark: hwm_next = max(hwm, count_next); updated in the same cycle as count.
- Total-accept counter: increments on each inc (including an inc that overflows); saturates at 2^cnt_width_p - 1 with no wrap.
- clear_i[i] asserted:
  - total <= 0; a same-cycle inc is not counted.
  - hwm <= count_next.
  - ovf/unf <= 0, except an error event in the same cycle sets its flag (event wins over clear).
  - Occupancy is never cleared.
- Snapshot: snap_i captures, for every channel, the register values present in the snap cycle (pre-update, i.e. the values on count_o that cycle). Shadow registers update on the following edge; all channels are captured coherently.
- Read port:
  - rd_v_i in cycle N -> rd_v_o = 1 in cycle N+1, with shadow fields of channel rd_sel_i sampled in cycle N.
  - rd_v_o = 0 in cycles with no request.
  - rd_*_o hold their last value when rd_v_o = 0.
  - Back-to-back reads are allowed, one per cycle.
- snap_i and rd_v_i in the same cycle: the read returns the old shadow contents.
- rd_sel_i >= total_stat_p: rd_v_o = 1, all rd data fields = 0.
- No handshake back-pressure; the block never stalls inputs. Channels are fully independent.

Test Plan:
- Fill/drain (els_p=4, total_stat_p=3, cnt_width_p=8): 3 accepts on ch1, then 1 yumi, then snap, then read sel=1 -> count=2, hwm=3, total=3, err=00; ch0 and ch2 read all zero.
- Overflow/underflow: 5 accepts on ch0 with no yumi -> count_o[0]=4, ovf=1. Then 5 yumis -> count=0, unf=1. Snap and read -> err=11, hwm=4.
- Simultaneous and cut-through: inc and dec together at count 0 and at count 4 -> count unchanged, no error flags, total increments by 1 each cycle.
- Saturation and clear: 300 accept/yumi pairs on ch2 -> total=255. Assert clear_i[2] with a concurrent inc -> total=0 and hwm=current count. A concurrent underflow with clear -> unf=1.
- Snapshot coherency and read timing:
  - Snap while ch0 is incrementing -> shadow holds the pre-update value.
  - snap and read in the same cycle -> old shadow returned.
  - rd_sel=3 -> rd_v_o=1 with zero data.
  - Back-to-back reads -> one rd_v_o per cycle.
- Async reset mid-operation: assert reset_i between edges with count=3 and a pending read -> count_o, shadow, and rd_v_o are 0 immediately, without waiting for a clock edge.
